// File: rtl/pipeline_pkg.sv
// Shared encodings for the pipeline sequencer:
// FSM state codes, NOP word, register-zero index.
package pipeline_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_STEP   = 3'd2,
    S_DRAIN  = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam logic [4:0]  REG_ZERO = 5'd0;

endpackage

// File: rtl/pipeline_sequencer_if.sv
// Debug-unit and hazard inputs plus the stage
// control outputs of the pipeline sequencer.
interface pipeline_sequencer_if #(
  parameter int CNT_W = 32
);

  logic             i_run;
  logic             i_step;
  logic             i_halt_ID;
  logic             i_halt_WB;
  logic             i_flg_mem_rd_EX;
  logic [4:0]       i_rt_EX;
  logic [4:0]       i_rs_ID;
  logic [4:0]       i_rt_ID;
  logic             i_flg_uses_rt_ID;
  logic             i_flg_branch_taken;
  logic             o_pc_en;
  logic             o_IF_ID_en;
  logic             o_IF_ID_flush;
  logic             o_ID_EX_bubble;
  logic             o_pipe_en;
  logic             o_halted;
  logic             o_drain_err;
  logic [2:0]       o_state;
  logic [CNT_W-1:0] o_cycle_count;
  logic [CNT_W-1:0] o_stall_count;

  modport master (
    output i_run, i_step, i_halt_ID, i_halt_WB,
    output i_flg_mem_rd_EX, i_rt_EX, i_rs_ID,
    output i_rt_ID, i_flg_uses_rt_ID,
    output i_flg_branch_taken,
    input  o_pc_en, o_IF_ID_en, o_IF_ID_flush,
    input  o_ID_EX_bubble, o_pipe_en, o_halted,
    input  o_drain_err, o_state,
    input  o_cycle_count, o_stall_count
  );

  modport slave (
    input  i_run, i_step, i_halt_ID, i_halt_WB,
    input  i_flg_mem_rd_EX, i_rt_EX, i_rs_ID,
    input  i_rt_ID, i_flg_uses_rt_ID,
    input  i_flg_branch_taken,
    output o_pc_en, o_IF_ID_en, o_IF_ID_flush,
    output o_ID_EX_bubble, o_pipe_en, o_halted,
    output o_drain_err, o_state,
    output o_cycle_count, o_stall_count
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of
// wrapping; clear has priority over increment.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_q
);

  // count up, hold at saturation
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr)
      o_q <= '0;
    else if (i_inc && (o_q != '1))
      o_q <= o_q + 1'b1;
  end

endmodule

// File: rtl/pipeline_sequencer.sv
// Pipeline run/step/halt sequencer with load-use
// stall insertion and drain watchdog.
module pipeline_sequencer
  import pipeline_pkg::*;
#(
  parameter int DRAIN_MAX = 6,
  parameter int CNT_W     = 32
) (
  input logic                 i_clk,
  input logic                 i_rst,
  pipeline_sequencer_if.slave bus
);

  localparam int DW = $clog2(DRAIN_MAX + 1);

  state_t        state;
  state_t        nxt;
  logic          adv;
  logic          rt_hit;
  logic          lu;
  logic          drain_done;
  logic          drain_err;
  logic [DW-1:0] drain_q;

  assign adv = (state == S_RUN) ||
               (state == S_STEP) ||
               (state == S_DRAIN);

  assign rt_hit =
    (bus.i_rt_EX == bus.i_rs_ID) ||
    (bus.i_flg_uses_rt_ID &&
     (bus.i_rt_EX == bus.i_rt_ID));

  assign lu = adv && (state != S_DRAIN) &&
              bus.i_flg_mem_rd_EX &&
              (bus.i_rt_EX != REG_ZERO) &&
              rt_hit;

  assign drain_done =
    (int'(drain_q) + 1) >= DRAIN_MAX;

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (1'b0),
    .i_inc (adv),
    .o_q   (bus.o_cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (1'b0),
    .i_inc (lu),
    .o_q   (bus.o_stall_count)
  );

  sat_counter #(.W(DW)) u_drain_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (state != S_DRAIN),
    .i_inc (state == S_DRAIN),
    .o_q   (drain_q)
  );

  // state register
  always_ff @(posedge i_clk) begin
    if (i_rst)
      state <= S_IDLE;
    else
      state <= nxt;
  end

  // sticky watchdog flag, cleared only by reset
  always_ff @(posedge i_clk) begin
    if (i_rst)
      drain_err <= 1'b0;
    else if ((state == S_DRAIN) &&
             !bus.i_halt_WB && drain_done)
      drain_err <= 1'b1;
  end

  // next-state decode
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: begin
        if (bus.i_run)
          nxt = S_RUN;
        else if (bus.i_step)
          nxt = S_STEP;
      end
      S_RUN: begin
        if (!lu && bus.i_halt_ID)
          nxt = S_DRAIN;
        else if (!bus.i_run)
          nxt = S_IDLE;
      end
      S_STEP: begin
        if (!lu && bus.i_halt_ID)
          nxt = S_DRAIN;
        else
          nxt = S_IDLE;
      end
      S_DRAIN: begin
        if (bus.i_halt_WB || drain_done)
          nxt = S_HALTED;
      end
      S_HALTED: nxt = S_HALTED;
      default:  nxt = S_IDLE;
    endcase
  end

  // stage enables, flush and bubble
  always_comb begin
    bus.o_pipe_en      = adv;
    bus.o_pc_en        = adv && !lu &&
                         (state != S_DRAIN);
    bus.o_IF_ID_en     = adv && !lu;
    bus.o_ID_EX_bubble = lu;
    bus.o_IF_ID_flush  = adv && !lu &&
                         (bus.i_flg_branch_taken ||
                          (state == S_DRAIN) ||
                          bus.i_halt_ID);
    bus.o_halted       = (state == S_HALTED);
    bus.o_drain_err    = drain_err;
    bus.o_state        = state;
  end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Randomized bench for pipeline_sequencer against
// a behavioural model of run/step/drain rules.
module tb_pipeline_sequencer;

  localparam int DMAX = 6;
  localparam int CW   = 6;
  localparam int SMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  pipeline_sequencer_if #(.CNT_W(CW)) bus ();

  pipeline_sequencer #(
    .DRAIN_MAX (DMAX),
    .CNT_W     (CW)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // model: 0 idle, 1 run, 2 step, 3 drain, 4 halted
  int m_st;
  int m_cyc;
  int m_stl;
  int m_dn;
  bit m_err;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic clear_in();
    bus.i_run              = 1'b0;
    bus.i_step             = 1'b0;
    bus.i_halt_ID          = 1'b0;
    bus.i_halt_WB          = 1'b0;
    bus.i_flg_mem_rd_EX    = 1'b0;
    bus.i_rt_EX            = 5'd0;
    bus.i_rs_ID            = 5'd0;
    bus.i_rt_ID            = 5'd0;
    bus.i_flg_uses_rt_ID   = 1'b0;
    bus.i_flg_branch_taken = 1'b0;
  endtask

  function automatic bit m_adv();
    return (m_st >= 1) && (m_st <= 3);
  endfunction

  function automatic bit m_lu();
    bit dep;
    dep = (bus.i_rt_EX == bus.i_rs_ID) ||
          (bus.i_flg_uses_rt_ID &&
           bus.i_rt_EX == bus.i_rt_ID);
    return m_adv() && m_st != 3 &&
           bus.i_flg_mem_rd_EX &&
           bus.i_rt_EX != 0 && dep;
  endfunction

  task automatic m_reset();
    m_st  = 0;
    m_cyc = 0;
    m_stl = 0;
    m_dn  = 0;
    m_err = 1'b0;
  endtask

  task automatic m_edge();
    bit a;
    bit l;
    a = m_adv();
    l = m_lu();
    if (rst) begin
      m_reset();
      return;
    end
    if (a && m_cyc < SMAX) m_cyc++;
    if (l && m_stl < SMAX) m_stl++;
    case (m_st)
      0: m_st = bus.i_run ? 1 : (bus.i_step ? 2 : 0);
      1: begin
        if (!l && bus.i_halt_ID) begin
          m_st = 3;
          m_dn = 0;
        end else if (!bus.i_run) m_st = 0;
      end
      2: begin
        if (!l && bus.i_halt_ID) begin
          m_st = 3;
          m_dn = 0;
        end else m_st = 0;
      end
      3: begin
        if (bus.i_halt_WB) m_st = 4;
        else begin
          m_dn++;
          if (m_dn >= DMAX) begin
            m_st  = 4;
            m_err = 1'b1;
          end
        end
      end
      default: m_st = 4;
    endcase
  endtask

  task automatic tick();
    bit a;
    bit l;
    #1;
    a = m_adv();
    l = m_lu();
    chk("state", bus.o_state, m_st);
    chk("pipe_en", bus.o_pipe_en, a);
    chk("pc_en", bus.o_pc_en, a && !l && m_st != 3);
    chk("ifid_en", bus.o_IF_ID_en, a && !l);
    chk("bubble", bus.o_ID_EX_bubble, l);
    chk("flush", bus.o_IF_ID_flush,
        a && !l && (bus.i_flg_branch_taken ||
                    m_st == 3 || bus.i_halt_ID));
    chk("halted", bus.o_halted, m_st == 4);
    chk("drain_err", bus.o_drain_err, m_err);
    chk("cycles", bus.o_cycle_count, m_cyc);
    chk("stalls", bus.o_stall_count, m_stl);
    @(posedge clk);
    m_edge();
    @(negedge clk);
  endtask

  initial begin
    int n;
    int c0;
    clear_in();
    rst = 1'b1;
    m_reset();
    @(posedge clk);
    @(negedge clk);
    tick();
    rst = 1'b0;
    chk("rst_cycles", bus.o_cycle_count, 0);
    chk("rst_state", bus.o_state, 0);

    bus.i_run = 1'b1;
    repeat (11) tick();
    chk("cyc10", bus.o_cycle_count, 10);
    chk("run_state", bus.o_state, 1);

    bus.i_flg_mem_rd_EX = 1'b1;
    bus.i_rt_EX = 5'd5;
    bus.i_rs_ID = 5'd5;
    #1;
    chk("lu_pc_en", bus.o_pc_en, 0);
    chk("lu_bubble", bus.o_ID_EX_bubble, 1);
    tick();
    chk("stall1", bus.o_stall_count, 1);
    bus.i_rt_EX = 5'd0;
    bus.i_rs_ID = 5'd0;
    #1;
    chk("r0_nostall", bus.o_ID_EX_bubble, 0);
    tick();
    clear_in();
    bus.i_run = 1'b1;

    bus.i_flg_branch_taken = 1'b1;
    #1;
    chk("br_flush", bus.o_IF_ID_flush, 1);
    tick();
    bus.i_flg_mem_rd_EX  = 1'b1;
    bus.i_rt_EX          = 5'd3;
    bus.i_rt_ID          = 5'd3;
    bus.i_rs_ID          = 5'd7;
    bus.i_flg_uses_rt_ID = 1'b1;
    #1;
    chk("br_lu_flush", bus.o_IF_ID_flush, 0);
    chk("br_lu_bub", bus.o_ID_EX_bubble, 1);
    tick();
    clear_in();

    tick();
    tick();
    c0 = m_cyc;
    bus.i_step = 1'b1;
    tick();
    tick();
    bus.i_step = 1'b0;
    chk("step_idle", bus.o_state, 0);
    chk("step_cyc", bus.o_cycle_count, c0 + 1);
    tick();

    bus.i_run = 1'b1;
    tick();
    bus.i_halt_ID = 1'b1;
    tick();
    bus.i_halt_ID = 1'b0;
    chk("drain_ent", bus.o_state, 3);
    tick();
    tick();
    bus.i_halt_WB = 1'b1;
    tick();
    bus.i_halt_WB = 1'b0;
    chk("halt_wb", bus.o_halted, 1);
    chk("halt_noerr", bus.o_drain_err, 0);
    repeat (4) begin
      bus.i_run = ~bus.i_run;
      tick();
    end
    chk("halt_stuck", bus.o_state, 4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_idle", bus.o_state, 0);

    bus.i_run = 1'b1;
    tick();
    bus.i_halt_ID = 1'b1;
    tick();
    bus.i_halt_ID = 1'b0;
    n = 0;
    while (bus.o_state == 3'd3 && n < 20) begin
      tick();
      n++;
    end
    chk("drain_len", n, DMAX);
    chk("drain_err", bus.o_drain_err, 1);
    chk("drain_halt", bus.o_state, 4);
    bus.i_run = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("err_clr", bus.o_drain_err, 0);

    bus.i_run = 1'b1;
    repeat (70) tick();
    chk("sat_cyc", bus.o_cycle_count, SMAX);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    repeat (2000) begin
      rst = ($urandom % 80) == 0;
      if (m_st == 4 && ($urandom % 8) == 0)
        rst = 1'b1;
      bus.i_run   = ($urandom % 4) != 0;
      bus.i_step  = ($urandom % 5) == 0;
      bus.i_halt_ID = ($urandom % 25) == 0;
      bus.i_halt_WB = ($urandom % 4) == 0;
      bus.i_flg_mem_rd_EX = $urandom % 2;
      bus.i_rt_EX = 5'($urandom % 4);
      bus.i_rs_ID = 5'($urandom % 4);
      bus.i_rt_ID = 5'($urandom % 4);
      bus.i_flg_uses_rt_ID = $urandom % 2;
      bus.i_flg_branch_taken = ($urandom % 6) == 0;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_sequencer.md
Name: pipeline_sequencer

Overview:
- Central sequencing controller for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
- Generates per-stage register enables, the IF/ID flush and the ID/EX bubble insertion, and inserts one bubble on a load-use hazard.
- Drives debug-unit run/step/halt execution: sequences the drain after a HALT instruction and exposes cycle and stall counters to the debug unit.
- Complements the forwarding logic: it handles the hazards that forwarding cannot resolve.

Parameters:
- DRAIN_MAX, 6, max cycles allowed in DRAIN before a forced halt.
- CNT_W, 32, width of cycle and stall counters.

Ports:
- i_clk  in  1  system clock, all state on rising edge
- i_rst  in  1  synchronous active-high reset
- i_run  in  1  debug unit: continuous-run level
- i_step  in  1  debug unit: single-step pulse
- i_halt_ID  in  1  HALT opcode decoded in ID
- i_halt_WB  in  1  HALT instruction present in WB
- i_flg_mem_rd_EX  in  1  instruction in EX is a load
- i_rt_EX  in  5  load destination register in EX
- i_rs_ID  in  5  rs of instruction in ID
- i_rt_ID  in  5  rt of instruction in ID
- i_flg_uses_rt_ID  in  1  ID instruction reads rt
- i_flg_branch_taken  in  1  branch/jump resolved taken in ID
- o_pc_en  out  1  PC write enable
- o_IF_ID_en  out  1  IF/ID register enable
- o_IF_ID_flush  out  1  IF/ID loads NOP
- o_ID_EX_bubble  out  1  ID/EX loads control-zero bubble
- o_pipe_en  out  1  enable for ID/EX, EX/MEM, MEM/WB
- o_halted  out  1  program finished
- o_drain_err  out  1  drain watchdog expired (sticky)
- o_state  out  3  current FSM state code
- o_cycle_count  out  CNT_W  advance cycles since reset
- o_stall_count  out  CNT_W  load-use stall cycles since reset

Behaviour:
- States: IDLE=0, RUN=1, STEP=2, DRAIN=3, HALTED=4.
- Reset: state IDLE. All enables, flush, bubble, o_halted, o_drain_err and both counters are 0.
- adv (internal) = 1 when state is RUN, STEP or DRAIN; otherwise 0.
- Load-use stall: lu = adv & state!=DRAIN & i_flg_mem_rd_EX & i_rt_EX!=0 & (i_rt_EX==i_rs_ID | (i_flg_uses_rt_ID & i_rt_EX==i_rt_ID)).
- Outputs are combinational from state and inputs:
  - o_pipe_en = adv
  - o_pc_en = adv & !lu & state!=DRAIN
  - o_IF_ID_en = adv & !lu
  - o_ID_EX_bubble = lu
  - o_IF_ID_flush = adv & !lu & (i_flg_branch_taken | state==DRAIN | i_halt_ID)
- Priority: load-use stall beats branch flush and halt detection. The ID instruction is re-evaluated next cycle.
- Transitions:
  - IDLE: i_run -> RUN; else i_step -> STEP. i_run wins if both are high.
  - RUN: (!lu & i_halt_ID) -> DRAIN; else !i_run -> IDLE; else stay.
  - STEP: exactly one adv cycle. (!lu & i_halt_ID) -> DRAIN; else -> IDLE. i_step during STEP is ignored.
  - A stalled step is consumed: the bubble is inserted and the state returns to IDLE.
  - DRAIN: free-running regardless of i_run/i_step. PC is frozen; IF/ID is flushed every cycle.
    - i_halt_WB -> HALTED.
    - Drain counter reaches DRAIN_MAX -> HALTED and set o_drain_err.
  - HALTED: all enables 0, o_halted=1. Exit only via i_rst.
- Latency:
  - i_run sampled high at edge k -> first advance cycle is k+1.
  - i_run low at edge k -> last advance cycle is k.
  - i_step high at edge k -> the single advance is in cycle k+1; IDLE again at edge k+2.
- Counters:
  - o_cycle_count increments on each cycle with adv=1.
  - o_stall_count increments on each cycle with lu=1.
  - Both saturate at all-ones; no wrap.
- Drain counter: cleared on DRAIN entry, increments every DRAIN cycle.
- i_rst mid-DRAIN or mid-stall returns to the reset state on the next edge, with no residual flush or bubble.

Decomposition:
- Shared package (pipeline_pkg): state encodings, NOP encoding, register-zero constant.
- Sub-module sat_counter (width parameter, inc, clear) for the cycle, stall and drain counters.
- FSM and hazard logic stay in the top module.

Test Plan:
- Reset, then i_run=1, no hazards for 10 cycles -> o_cycle_count=10, o_pc_en=1 each cycle, o_state=1.
- RUN with i_flg_mem_rd_EX=1, i_rt_EX=5, i_rs_ID=5:
  - that cycle: o_pc_en=0, o_IF_ID_en=0, o_ID_EX_bubble=1, o_stall_count=1.
  - with i_rt_EX=0 instead: no stall.
- RUN with i_flg_branch_taken=1 and no lu -> o_IF_ID_flush=1 one cycle. With lu also 1 -> flush=0, bubble=1.
- IDLE, i_step pulse at edge k -> exactly one cycle with o_pipe_en=1, o_cycle_count+1, o_state back to 0 at k+2. A second i_step during STEP is ignored.
- RUN, i_halt_ID=1, then i_halt_WB=1 three cycles later:
  - DRAIN for 3 cycles with o_pc_en=0 and o_IF_ID_flush=1.
  - then o_halted=1, all enables 0.
  - i_run toggling afterwards has no effect; i_rst returns to IDLE.
- DRAIN with i_halt_WB never asserted -> after DRAIN_MAX=6 cycles: HALTED, o_drain_err=1. Reset clears o_drain_err.
